// File: rtl/jt10_adpcm_rom_fetch.sv
// ADPCM-A fetch stage: per-channel one-byte cache, request queue and ROM req/ok FSM.
// Nibbles reach the decoder one channel round (6 cen ticks) after intake.
module jt10_adpcm_rom_fetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [5:0]  cur_ch,
  input  logic [19:0] addr,
  input  logic [4:0]  bank,
  input  logic        sel,
  input  logic        roe_n,
  input  logic        decon,
  input  logic        clr,
  output logic [24:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic [3:0]  data,
  output logic        decon_out,
  output logic        clr_out,
  output logic        late,
  output logic        ovf,
  input  logic        clr_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [24:0]        tag_q    [6];
  logic [5:0]         tag_v_q, byte_v_q, sel_q, decon_q, clr_q;
  logic [7:0]         byte_q   [6];
  logic [27:0]        q_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [24:0]        rom_addr_q;
  logic [2:0]         req_ch_q;
  logic [3:0]         data_q;
  logic               decon_out_q, clr_out_q, late_q, ovf_q;
  logic               late_d, ovf_d;

  logic [2:0]  ch_idx;
  logic        ch_ok, intake, hit, fetch, full, push, drop, pop, capture;
  logic [24:0] req_tag;

  always_comb begin
    ch_idx = '0;
    ch_ok  = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (cur_ch[i] && !ch_ok) begin
        ch_idx = 3'(i);
        ch_ok  = 1'b1;
      end
    end
  end

  // A clr in the same slot starts a new section, so it never counts as a cache hit.
  assign req_tag = {bank, addr};
  assign intake  = cen && ch_ok;
  assign hit     = tag_v_q[ch_idx] && !clr && (tag_q[ch_idx] == req_tag);
  assign fetch   = intake && !roe_n && !hit;
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign push    = fetch && !full;
  assign drop    = fetch && full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cnt_q != '0) state_d = S_WAIT;
      S_WAIT:  if (rom_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = (state_q == S_IDLE) && (cnt_q != '0);
    capture = (state_q == S_WAIT) && rom_ok;
    rom_cs  = (state_q == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= {ch_idx, req_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      req_ch_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q   <= ptr_inc(rd_ptr_q);
        rom_addr_q <= q_mem[rd_ptr_q][24:0];
        req_ch_q   <= q_mem[rd_ptr_q][27:25];
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ROM capture is written first so a same-cycle intake on that channel overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 6; i++) begin
        tag_q[i]  <= '0;
        byte_q[i] <= '0;
      end
      tag_v_q  <= '0;
      byte_v_q <= '0;
      sel_q    <= '0;
      decon_q  <= '0;
      clr_q    <= '0;
    end else begin
      if (capture && tag_v_q[req_ch_q] && (tag_q[req_ch_q] == rom_addr_q)) begin
        byte_q[req_ch_q]   <= rom_data;
        byte_v_q[req_ch_q] <= 1'b1;
      end
      if (intake) begin
        sel_q[ch_idx]   <= sel;
        decon_q[ch_idx] <= decon;
        clr_q[ch_idx]   <= clr;
        if (clr) begin
          tag_v_q[ch_idx]  <= 1'b0;
          byte_v_q[ch_idx] <= 1'b0;
        end
        if (fetch) begin
          tag_q[ch_idx]    <= req_tag;
          tag_v_q[ch_idx]  <= 1'b1;
          byte_v_q[ch_idx] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    late_d = late_q | (intake && decon_q[ch_idx] && !byte_v_q[ch_idx]);
    ovf_d  = ovf_q | drop;
    if (clr_err) begin
      late_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      decon_out_q <= 1'b0;
      clr_out_q   <= 1'b0;
      late_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      late_q <= late_d;
      ovf_q  <= ovf_d;
      if (intake) begin
        data_q      <= (decon_q[ch_idx] && byte_v_q[ch_idx]) ?
                       (sel_q[ch_idx] ? byte_q[ch_idx][3:0] : byte_q[ch_idx][7:4]) : '0;
        decon_out_q <= decon_q[ch_idx];
        clr_out_q   <= clr_q[ch_idx];
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign data      = data_q;
  assign decon_out = decon_out_q;
  assign clr_out   = clr_out_q;
  assign late      = late_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_jt10_adpcm_rom_fetch.sv
// Directed bench for jt10_adpcm_rom_fetch: cache hits, queueing, late/overflow flags, clr and reset.
module tb_jt10_adpcm_rom_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [5:0]  cur_ch = '0;
  logic [19:0] addr = '0;
  logic [4:0]  bank = '0;
  logic        sel = 1'b0, roe_n = 1'b1, decon = 1'b0, clr = 1'b0;
  logic [24:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;
  logic [3:0]  data;
  logic        decon_out, clr_out, late, ovf;
  logic        clr_err = 1'b0;

  int checks = 0;
  int failures = 0;

  bit          manual = 1'b0;
  bit          ok_en = 1'b1;
  int          ok_delay = 3;
  int          cs_cnt = 0;
  int          cs_rises = 0;
  logic        cs_prev = 1'b0;
  logic [24:0] addr_log[$];

  logic [3:0] o_data;
  logic       o_decon, o_clr;

  jt10_adpcm_rom_fetch #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cur_ch(cur_ch), .addr(addr), .bank(bank),
    .sel(sel), .roe_n(roe_n), .decon(decon), .clr(clr), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .data(data),
    .decon_out(decon_out), .clr_out(clr_out), .late(late), .ovf(ovf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [24:0] a);
    if (a == {5'd2, 20'h00100}) return 8'h5A;
    return a[7:0] ^ 8'hC3;
  endfunction

  function automatic logic [3:0] nib(input logic [7:0] b, input logic s);
    return s ? b[3:0] : b[7:4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ROM model: answers ok_delay clocks after rom_cs rises, logs each request.
  always @(negedge clk) begin
    if (rom_cs && !cs_prev) begin
      cs_rises++;
      addr_log.push_back(rom_addr);
    end
    cs_prev = rom_cs;
    if (!manual) begin
      if (rom_cs && ok_en) begin
        cs_cnt++;
        if (cs_cnt >= ok_delay) begin
          rom_ok   = 1'b1;
          rom_data = rom_f(rom_addr);
        end else begin
          rom_ok = 1'b0;
        end
      end else begin
        cs_cnt = 0;
        rom_ok = 1'b0;
      end
    end
  end

  task automatic slot(input int ch, input logic [4:0] b, input logic [19:0] a,
                      input logic s, input logic r, input logic d, input logic c);
    @(negedge clk);
    cur_ch = 6'b1 << ch;
    bank = b; addr = a; sel = s; roe_n = r; decon = d; clr = c;
    cen = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0; roe_n = 1'b1; decon = 1'b0; clr = 1'b0;
    o_data = data; o_decon = decon_out; o_clr = clr_out;
    repeat (7) @(posedge clk);
  endtask

  task automatic idle(input int ch);
    slot(ch, 5'd0, 20'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr_err();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  logic [4:0]  tb_bank[6];
  logic [19:0] tb_addr[6];
  int          base;

  initial begin
    do_reset();
    #1;
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_data", data, 0);
    chk("rst_decon_out", decon_out, 0);
    chk("rst_clr_out", clr_out, 0);
    chk("rst_late", late, 0);
    chk("rst_ovf", ovf, 0);

    // Single channel, two nibbles of 0x5A, second is a cache hit.
    ok_delay = 3; ok_en = 1'b1;
    base = cs_rises;
    slot(0, 5'd2, 20'h00100, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) idle(i);
    slot(0, 5'd2, 20'h00100, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_hi_nibble", o_data, 4'h5);
    chk("t1_decon_out", o_decon, 1);
    for (int i = 1; i < 6; i++) idle(i);
    idle(0);
    chk("t1_lo_nibble", o_data, 4'hA);
    chk("t1_one_request", cs_rises - base, 1);
    chk("t1_rom_addr", addr_log[base], {5'd2, 20'h00100});
    chk("t1_no_late", late, 0);

    // All six channels miss in consecutive slots.
    do_reset();
    ok_delay = 2;
    base = cs_rises;
    for (int i = 0; i < 6; i++) begin
      tb_bank[i] = 5'(i + 1);
      tb_addr[i] = 20'(32'h1000 * i + 32'h20 + i);
      slot(i, tb_bank[i], tb_addr[i], 1'(i % 2), 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      idle(i);
      chk($sformatf("t2_data_ch%0d", i), o_data, nib(rom_f({tb_bank[i], tb_addr[i]}), 1'(i % 2)));
    end
    chk("t2_requests", cs_rises - base, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_addr_ch%0d", i), addr_log[base + i], {tb_bank[i], tb_addr[i]});
    chk("t2_no_late", late, 0);
    chk("t2_no_ovf", ovf, 0);

    // Late answer: flagged, cleared, then served from cache.
    do_reset();
    ok_en = 1'b0; ok_delay = 2;
    for (int i = 0; i < 6; i++)
      if (i == 2) slot(2, 5'd3, 20'h02345, 1'b0, 1'b0, 1'b1, 1'b0); else idle(i);
    for (int i = 0; i < 2; i++) idle(i);
    slot(2, 5'd3, 20'h02345, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_late_data", o_data, 0);
    chk("t3_late_set", late, 1);
    pulse_clr_err();
    #1;
    chk("t3_late_cleared", late, 0);
    ok_en = 1'b1;
    for (int i = 3; i < 6; i++) idle(i);
    for (int i = 0; i < 3; i++) idle(i);
    chk("t3_cached_nibble", o_data, nib(rom_f({5'd3, 20'h02345}), 1'b1));
    chk("t3_late_stays_clear", late, 0);

    // Overflow: one in flight, four queued, sixth dropped.
    do_reset();
    ok_en = 1'b0;
    base = cs_rises;
    for (int i = 0; i < 5; i++) slot(i, 5'd7, 20'(32'h400 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_no_ovf_at_4", ovf, 0);
    slot(5, 5'd7, 20'h00405, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_ovf", ovf, 1);
    chk("t4_one_rise", cs_rises - base, 1);
    chk("t4_cs_held", rom_cs, 1);
    pulse_clr_err();
    #1;
    chk("t4_ovf_cleared", ovf, 0);

    // clr while the fetch is outstanding: returning byte discarded.
    do_reset();
    ok_en = 1'b0;
    for (int i = 0; i < 6; i++)
      if (i == 3) slot(3, 5'd1, 20'h00333, 1'b0, 1'b0, 1'b1, 1'b0); else idle(i);
    for (int i = 0; i < 3; i++) idle(i);
    slot(3, 5'd0, 20'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    ok_en = 1'b1;
    for (int i = 4; i < 6; i++) idle(i);
    for (int i = 0; i < 3; i++) idle(i);
    idle(3);
    chk("t5_clr_out", o_clr, 1);
    chk("t5_data_discarded", o_data, 0);
    chk("t5_cs_done", rom_cs, 0);

    // Asynchronous reset mid-request.
    do_reset();
    manual = 1'b1; rom_ok = 1'b0;
    base = cs_rises;
    slot(1, 5'd4, 20'h00044, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_cs_before", rom_cs, 1);
    chk("t6_addr_before", rom_addr, {5'd4, 20'h00044});
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_cs_async", rom_cs, 0);
    chk("t6_addr_async", rom_addr, 0);
    chk("t6_data_async", data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rom_ok = 1'b1; rom_data = 8'hFF;
    repeat (3) @(negedge clk);
    rom_ok = 1'b0;
    #1;
    chk("t6_cs_after_ok", rom_cs, 0);
    chk("t6_rises", cs_rises - base, 1);
    slot(1, 5'd0, 20'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 2; i < 6; i++) idle(i);
    idle(0);
    idle(1);
    chk("t6_data_zero", o_data, 0);
    chk("t6_decon_out", o_decon, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
